// File: rtl/tiny_rv32i_soc_if.sv
// Instruction-fetch bus between the core (master) and the instruction ROM (slave).
interface tiny_rv32i_soc_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rdata;

  modport master (output addr, input rdata);
  modport slave  (input addr, output rdata);
endinterface

// File: rtl/tiny_rv32i_soc.sv
// Minimal RV32I SoC: combinational instruction ROM feeding a single-cycle integer core.
// Every instruction fetches, executes and commits pc/writeback on one rising edge.

module rv_rom #(
  parameter int ROM_DEPTH = 4096
) (
  tiny_rv32i_soc_if.slave imem
);
  // Filled hierarchically by the system bench before reset release.
  logic [31:0] rom_mem [0:ROM_DEPTH-1];

  assign imem.rdata = rom_mem[imem.addr];
endmodule

module rv_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  // Register array; x0 is never written so it stays zero from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
endmodule

module rv_core #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  tiny_rv32i_soc_if.master imem
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;
  logic        wb_en;
  logic [31:0] wb_data;
  logic        r_legal, i_legal, i_alt;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic alt);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, ($signed(a) < $signed(b))};
      3'b011:  r = {31'd0, (a < b)};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Funct3 010/011 are not branch encodings and never take.
  function automatic logic br_taken_f(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3);
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign imem.addr = pc_q[ADDR_W+1:2];
  assign instr     = imem.rdata;
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'd0};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4  = pc_q + 32'd4;

  assign r_legal = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  // Shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 30.
  always_comb begin
    i_legal = 1'b1;
    i_alt   = 1'b0;
    case (funct3)
      3'b001: i_legal = (funct7 == 7'b0000000);
      3'b101: begin
        i_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        i_alt   = instr[30];
      end
      default: begin
        i_legal = 1'b1;
        i_alt   = 1'b0;
      end
    endcase
  end

  rv_regfile regs_inst (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  // Decode/execute: anything unrecognised falls through as a NOP.
  always_comb begin
    pc_d    = pc_plus4;
    wb_en   = 1'b0;
    wb_data = 32'd0;
    case (opcode)
      OP_R: begin
        if (r_legal) begin
          wb_en   = 1'b1;
          wb_data = alu_f(rs1_val, rs2_val, funct3, instr[30]);
        end else begin
          wb_en   = 1'b0;
        end
      end
      OP_I: begin
        if (i_legal) begin
          wb_en   = 1'b1;
          wb_data = alu_f(rs1_val, imm_i, funct3, i_alt);
        end else begin
          wb_en   = 1'b0;
        end
      end
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc_q + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_d    = pc_q + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          pc_d    = (rs1_val + imm_i) & ~32'd1;
        end else begin
          wb_en   = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (br_taken_f(rs1_val, rs2_val, funct3)) begin
          pc_d = pc_q + imm_b;
        end else begin
          pc_d = pc_plus4;
        end
      end
      default: begin
        pc_d  = pc_plus4;
        wb_en = 1'b0;
      end
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end
endmodule

module tiny_rv32i_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst_n
);
  localparam int AW = $clog2(ROM_DEPTH);

  tiny_rv32i_soc_if #(.ADDR_W(AW)) imem_bus ();

  rv_rom #(.ROM_DEPTH(ROM_DEPTH)) rom_inst (
    .imem (imem_bus.slave)
  );

  rv_core #(.ADDR_W(AW), .RESET_PC(RESET_PC)) riscv_core_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .imem  (imem_bus.master)
  );
endmodule

// File: tb/tb_tiny_rv32i_soc.sv
// Directed bench for tiny_rv32i_soc: preloads small programs into the ROM and checks
// the register file and pc hierarchically after a known number of clock edges.
module tb_tiny_rv32i_soc;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] prog [$];

  tiny_rv32i_soc dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm20, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm20, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'd0;
    for (int i = 0; i < prog.size(); i++) dut.rom_inst.rom_mem[i] = prog[i];
  endtask

  // Hold reset for n edges while checking it, then release on a falling edge.
  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    load_rom();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_pc",  dut.riscv_core_inst.pc_q, 32'd0);
      chk("rst_x27", dut.riscv_core_inst.regs_inst.regs[27], 32'd0);
      chk("rst_x28", dut.riscv_core_inst.regs_inst.regs[28], 32'd0);
      chk("rst_x29", dut.riscv_core_inst.regs_inst.regs[29], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_add_prog();
    prog = {};
    prog.push_back(enc_i(5, 5'd0, 3'b000, 5'd27, 7'b0010011));
    prog.push_back(enc_i(7, 5'd0, 3'b000, 5'd28, 7'b0010011));
    prog.push_back(enc_r(7'b0000000, 5'd28, 5'd27, 3'b000, 5'd29));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;

    // ADD test
    set_add_prog();
    hold_reset(1);
    run_edges(1);
    chk("add_x27_1edge", dut.riscv_core_inst.regs_inst.regs[27], 32'd5);
    chk("add_x28_1edge", dut.riscv_core_inst.regs_inst.regs[28], 32'd0);
    chk("add_pc_1edge",  dut.riscv_core_inst.pc_q, 32'd4);
    run_edges(2);
    chk("add_x27", dut.riscv_core_inst.regs_inst.regs[27], 32'd5);
    chk("add_x28", dut.riscv_core_inst.regs_inst.regs[28], 32'd7);
    chk("add_x29", dut.riscv_core_inst.regs_inst.regs[29], 32'd12);
    run_edges(4);
    chk("add_x29_stable", dut.riscv_core_inst.regs_inst.regs[29], 32'd12);
    chk("add_pc_nops",    dut.riscv_core_inst.pc_q, 32'd28);

    // SUB / wrap test
    prog = {};
    prog.push_back(enc_i(1, 5'd0, 3'b000, 5'd27, 7'b0010011));
    prog.push_back(enc_r(7'b0100000, 5'd27, 5'd0, 3'b000, 5'd28));
    prog.push_back(enc_r(7'b0000000, 5'd27, 5'd28, 3'b000, 5'd29));
    hold_reset(2);
    run_edges(4);
    chk("sub_x28", dut.riscv_core_inst.regs_inst.regs[28], 32'hFFFF_FFFF);
    chk("sub_x29", dut.riscv_core_inst.regs_inst.regs[29], 32'd0);

    // Branch loop test
    prog = {};
    prog.push_back(enc_i(3, 5'd0, 3'b000, 5'd27, 7'b0010011));
    prog.push_back(enc_i(-1, 5'd27, 3'b000, 5'd27, 7'b0010011));
    prog.push_back(enc_i(1, 5'd28, 3'b000, 5'd28, 7'b0010011));
    prog.push_back(enc_b(-8, 5'd0, 5'd27, 3'b001));
    hold_reset(2);
    run_edges(4);
    chk("loop_x27_iter1", dut.riscv_core_inst.regs_inst.regs[27], 32'd2);
    chk("loop_pc_back",   dut.riscv_core_inst.pc_q, 32'd4);
    run_edges(10);
    chk("loop_x27", dut.riscv_core_inst.regs_inst.regs[27], 32'd0);
    chk("loop_x28", dut.riscv_core_inst.regs_inst.regs[28], 32'd3);

    // x0 / JAL test
    prog = {};
    prog.push_back(enc_i(9, 5'd0, 3'b000, 5'd0, 7'b0010011));
    prog.push_back(enc_j(8, 5'd29));
    prog.push_back(enc_i(1, 5'd0, 3'b000, 5'd28, 7'b0010011));
    hold_reset(2);
    run_edges(2);
    chk("jal_pc", dut.riscv_core_inst.pc_q, 32'd12);
    run_edges(3);
    chk("jal_x0",  dut.riscv_core_inst.regs_inst.regs[0], 32'd0);
    chk("jal_x29", dut.riscv_core_inst.regs_inst.regs[29], 32'd8);
    chk("jal_x28", dut.riscv_core_inst.regs_inst.regs[28], 32'd0);

    // Shifts, compares, U-type, BLT and JALR
    prog = {};
    prog.push_back(enc_u(20'h80000, 5'd27, 7'b0110111));               // 0  lui
    prog.push_back(enc_i(12'h404, 5'd27, 3'b101, 5'd28, 7'b0010011));  // 4  srai 4
    prog.push_back(enc_r(7'b0000000, 5'd0, 5'd27, 3'b010, 5'd29));     // 8  slt
    prog.push_back(enc_i(31, 5'd27, 3'b101, 5'd26, 7'b0010011));       // 12 srli 31
    prog.push_back(enc_i(-1, 5'd28, 3'b100, 5'd25, 7'b0010011));       // 16 xori -1
    prog.push_back(enc_u(20'h00001, 5'd24, 7'b0010111));               // 20 auipc
    prog.push_back(enc_b(8, 5'd0, 5'd27, 3'b100));                     // 24 blt +8
    prog.push_back(enc_i(1, 5'd0, 3'b000, 5'd23, 7'b0010011));         // 28 skipped
    prog.push_back(enc_r(7'b0000000, 5'd27, 5'd0, 3'b011, 5'd22));     // 32 sltu
    prog.push_back(enc_i(45, 5'd0, 3'b000, 5'd21, 7'b1100111));        // 36 jalr
    prog.push_back(enc_i(1, 5'd0, 3'b000, 5'd20, 7'b0010011));         // 40 skipped
    prog.push_back(enc_i(12'h7FF, 5'd0, 3'b110, 5'd19, 7'b0010011));   // 44 ori
    hold_reset(2);
    run_edges(14);
    chk("mix_lui",   dut.riscv_core_inst.regs_inst.regs[27], 32'h8000_0000);
    chk("mix_srai",  dut.riscv_core_inst.regs_inst.regs[28], 32'hF800_0000);
    chk("mix_slt",   dut.riscv_core_inst.regs_inst.regs[29], 32'd1);
    chk("mix_srli",  dut.riscv_core_inst.regs_inst.regs[26], 32'd1);
    chk("mix_xori",  dut.riscv_core_inst.regs_inst.regs[25], 32'h07FF_FFFF);
    chk("mix_auipc", dut.riscv_core_inst.regs_inst.regs[24], 32'h0000_1014);
    chk("mix_blt",   dut.riscv_core_inst.regs_inst.regs[23], 32'd0);
    chk("mix_sltu",  dut.riscv_core_inst.regs_inst.regs[22], 32'd1);
    chk("mix_jalr",  dut.riscv_core_inst.regs_inst.regs[21], 32'd40);
    chk("mix_jskip", dut.riscv_core_inst.regs_inst.regs[20], 32'd0);
    chk("mix_ori",   dut.riscv_core_inst.regs_inst.regs[19], 32'h0000_07FF);

    // Async reset mid-program, then the ADD program reruns
    set_add_prog();
    hold_reset(2);
    run_edges(2);
    chk("mid_x28_before", dut.riscv_core_inst.regs_inst.regs[28], 32'd7);
    chk("mid_pc_before",  dut.riscv_core_inst.pc_q, 32'd8);
    #4;
    rst_n = 1'b0;
    #1;
    chk("mid_pc_async",  dut.riscv_core_inst.pc_q, 32'd0);
    chk("mid_x27_async", dut.riscv_core_inst.regs_inst.regs[27], 32'd0);
    chk("mid_x28_async", dut.riscv_core_inst.regs_inst.regs[28], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_edges(3);
    chk("mid_x27", dut.riscv_core_inst.regs_inst.regs[27], 32'd5);
    chk("mid_x28", dut.riscv_core_inst.regs_inst.regs[28], 32'd7);
    chk("mid_x29", dut.riscv_core_inst.regs_inst.regs[29], 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
